fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 11: number of valid instruction words, addresses 0..MEM_WORDS-1.
REQ-002 SHALL have parameter RESET_PC, default 0: word address loaded into PC on reset.
REQ-003 SHALL have parameter JMP_OPCODE, default 6'h02: opcode in instruction[31:26] that denotes an unconditional jump.
REQ-004 SHALL have parameter JMP_LIMIT, default 4: maximum consecutive jumps without an emitted instruction.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports are listed in REQ-006..REQ-018.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 enable  in  1  fetch permitted.
REQ-009 imem_addr  out  32  word address to instruction memory; combinational copy of PC.
REQ-010 imem_instr  in  32  instruction word at imem_addr, valid in the same cycle.
REQ-011 redirect_valid  in  1  external PC load request.
REQ-012 redirect_target  in  32  word address for redirect.
REQ-013 out_valid  out  1  out_instr/out_pc hold a fetched instruction.
REQ-014 out_ready  in  1  consumer accepts when high with out_valid.
REQ-015 out_instr  out  32  fetched instruction.
REQ-016 out_pc  out  32  word address of out_instr.
REQ-017 fault  out  1  sticky fault flag.
REQ-018 fault_code  out  2  0 none, 1 address out of range, 2 jump loop.

Function
REQ-019 SHALL implement states IDLE, RUN, FAULT; IDLE->RUN when enable=1; RUN->IDLE when enable=0 (output stage holds); FAULT exits only on rst.
REQ-020 SHALL define "fire" = state RUN, enable=1, redirect_valid=0, and (out_valid=0 or out_ready=1).
REQ-021 On fire with PC > MEM_WORDS-1: SHALL enter FAULT, set fault=1, fault_code=1; no instruction is captured.
REQ-022 On fire with opcode == JMP_OPCODE: SHALL load PC <= {7'b0, imem_instr[24:0]}, not emit the jump word, increment the jump counter; this costs exactly one bubble cycle.
REQ-023 On a jump fire with jump counter == JMP_LIMIT-1: SHALL enter FAULT with fault_code=2 instead of taking the jump.
REQ-024 On fire with any other opcode: SHALL register out_instr<=imem_instr, out_pc<=PC, out_valid<=1, PC<=PC+1 (32-bit wrap), jump counter<=0.
REQ-025 If out_valid=1 and out_ready=1 and no emit occurs in that cycle: SHALL clear out_valid next cycle.
REQ-026 While out_valid=1 and out_ready=0: out_instr, out_pc and PC SHALL remain unchanged.
REQ-027 redirect_valid in RUN SHALL have priority: PC<=redirect_target, out_valid<=0 (flush, even if unaccepted), jump counter<=0; a transfer with out_ready=1 in that same cycle counts as accepted.
REQ-028 redirect_valid in IDLE SHALL load PC only; in FAULT it SHALL be ignored.
REQ-029 In FAULT, a pending out_valid SHALL drain normally via out_ready; no new fetch occurs.
REQ-030 Range check SHALL apply at fetch time only; out-of-range redirect or jump targets fault on the next fire.

Reset
REQ-031 On rst=1 at a clock edge: PC=RESET_PC, state=IDLE, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_code=0, jump counter=0, regardless of state or pending handshake.

Verification
REQ-032 mem[0..2]=00000011,00000022,00000033, enable=1, out_ready=1 -> out (pc,instr)=(0,11),(1,22),(2,33) on consecutive cycles, first one cycle after enable.
REQ-033 mem[1]=08000005, mem[5]=00000055 -> outputs (0,mem[0]), one bubble, (5,55); 08000005 never on out_instr.
REQ-034 out_ready=0 for 3 cycles while out_valid=1 -> out_pc, out_instr, imem_addr stable; after release, no lost or duplicated pc.
REQ-035 redirect_valid=1, target=3, while out_valid=1, out_ready=0 -> next cycle out_valid=0; next emitted (3,mem[3]).
REQ-036 mem[0]=0800000B with MEM_WORDS=11 -> fault=1, fault_code=1, out_valid stays 0; mem[0]=08000000 -> fault_code=2 after 4th jump fire; rst clears both.
REQ-037 rst asserted mid-stream with out_valid=1 -> next cycle out_valid=0, imem_addr=RESET_PC, state IDLE.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a word-addressed instruction memory,
// folds unconditional jumps, emits instructions through a valid/ready stage
// and latches sticky faults for out-of-range fetches and runaway jump chains.
module fetch_controller #(
    parameter int unsigned MEM_WORDS  = 11,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [5:0]  JMP_OPCODE = 6'h02,
    parameter int unsigned JMP_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int unsigned CNT_W = $clog2(JMP_LIMIT + 1);

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_RANGE = 2'd1;
    localparam logic [1:0] CODE_LOOP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   jcnt_q, jcnt_d;
    logic               valid_d;
    logic [31:0]        instr_d;
    logic [31:0]        opc_d;
    logic               fault_d;
    logic [1:0]         code_d;
    logic               fire;
    logic               is_jump;
    logic               in_range;

    assign imem_addr = pc_q;
    assign is_jump   = (imem_instr[31:26] == JMP_OPCODE);
    assign in_range  = (pc_q < 32'(MEM_WORDS));

    // Next-state and next-value logic for the FSM and the output stage
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        jcnt_d  = jcnt_q;
        valid_d = out_valid;
        instr_d = out_instr;
        opc_d   = out_pc;
        fault_d = fault;
        code_d  = fault_code;
        fire    = (state_q == RUN) && enable && !redirect_valid &&
                  (!out_valid || out_ready);

        // An accepted word leaves the stage unless replaced by a new emit below
        if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    jcnt_d  = '0;
                end
                if (!enable) begin
                    state_d = IDLE;
                end else if (fire) begin
                    if (!in_range) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        code_d  = CODE_RANGE;
                    end else if (is_jump) begin
                        if (jcnt_q == CNT_W'(JMP_LIMIT - 1)) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                            code_d  = CODE_LOOP;
                        end else begin
                            pc_d   = {7'b0, imem_instr[24:0]};
                            jcnt_d = jcnt_q + CNT_W'(1);
                        end
                    end else begin
                        instr_d = imem_instr;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd1;
                        jcnt_d  = '0;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            jcnt_q     <= '0;
            out_valid  <= 1'b0;
            out_instr  <= 32'd0;
            out_pc     <= 32'd0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            jcnt_q     <= jcnt_d;
            out_valid  <= valid_d;
            out_instr  <= instr_d;
            out_pc     <= opc_d;
            fault      <= fault_d;
            fault_code <= code_d;
        end
    end

endmodule
